writeback_arbiter: RTL

- Arbitrates the single physical-register-file write port, ready-table set port and ROB complete port among the execution units. Default requesters: 0 = ALU_0, 1 = ALU_1, 2 = LQ.
- Each requester has one holding buffer behind a valid/ready handshake.
- Each cycle, one buffered result is chosen by round-robin and broadcast combinationally on the writeback bus.
- Sits between the execution units and the reg file, ready table and ROB.

---
 rtl/writeback_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin arbiter for the shared writeback port
// One holding buffer per execution unit; one buffered result is broadcast per cycle.
module writeback_arbiter #(
    parameter int NUM_REQUESTERS  = 3,
    parameter int PHYS_REG_WIDTH  = 6,
    parameter int ROB_INDEX_WIDTH = 5,
    parameter int WORD_WIDTH      = 32,
    localparam int SRC_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic                                      CLK,
    input  logic                                      nRST,
    input  logic [NUM_REQUESTERS-1:0]                 req_valid,
    output logic [NUM_REQUESTERS-1:0]                 req_ready,
    input  logic [NUM_REQUESTERS-1:0]                 req_reg_write,
    input  logic [NUM_REQUESTERS*PHYS_REG_WIDTH-1:0]  req_dest_phys_reg_tag,
    input  logic [NUM_REQUESTERS*WORD_WIDTH-1:0]      req_data,
    input  logic [NUM_REQUESTERS*ROB_INDEX_WIDTH-1:0] req_ROB_index,
    input  logic                                      wb_stall,
    output logic                                      WB_valid,
    output logic                                      WB_reg_write,
    output logic [PHYS_REG_WIDTH-1:0]                 WB_phys_reg_tag,
    output logic [WORD_WIDTH-1:0]                     WB_data,
    output logic [ROB_INDEX_WIDTH-1:0]                WB_ROB_index,
    output logic [SRC_W-1:0]                          WB_source
);

    logic [NUM_REQUESTERS-1:0]  buf_valid;
    logic [NUM_REQUESTERS-1:0]  buf_reg_write;
    logic [PHYS_REG_WIDTH-1:0]  buf_tag  [NUM_REQUESTERS];
    logic [WORD_WIDTH-1:0]      buf_data [NUM_REQUESTERS];
    logic [ROB_INDEX_WIDTH-1:0] buf_rob  [NUM_REQUESTERS];

    logic [SRC_W-1:0]          ptr;
    logic [SRC_W-1:0]          grant_idx;
    logic                      found;
    logic [SRC_W:0]            scan;
    logic [NUM_REQUESTERS-1:0] grant;

    // Scan from the pointer; the wrap is an explicit compare so non-power-of-two counts work.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        if (!wb_stall) begin
            for (int j = 0; j < NUM_REQUESTERS; j++) begin
                scan = {1'b0, ptr} + (SRC_W+1)'(j);
                if (scan >= (SRC_W+1)'(NUM_REQUESTERS))
                    scan = scan - (SRC_W+1)'(NUM_REQUESTERS);
                if (!found && buf_valid[scan[SRC_W-1:0]]) begin
                    found     = 1'b1;
                    grant_idx = scan[SRC_W-1:0];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found)
            grant[grant_idx] = 1'b1;
    end

    assign req_ready = ~buf_valid | grant;

    assign WB_valid        = found;
    assign WB_reg_write    = found ? buf_reg_write[grant_idx] : 1'b0;
    assign WB_phys_reg_tag = found ? buf_tag[grant_idx]       : '0;
    assign WB_data         = found ? buf_data[grant_idx]      : '0;
    assign WB_ROB_index    = found ? buf_rob[grant_idx]       : '0;
    assign WB_source       = found ? grant_idx                : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == SRC_W'(NUM_REQUESTERS-1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    // A granted buffer accepting a new offer in the same cycle is refilled, not cleared.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_valid     <= '0;
            buf_reg_write <= '0;
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
                buf_rob[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_valid[i]     <= 1'b1;
                    buf_reg_write[i] <= req_reg_write[i];
                    buf_tag[i]       <= req_dest_phys_reg_tag[i*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
                    buf_data[i]      <= req_data[i*WORD_WIDTH +: WORD_WIDTH];
                    buf_rob[i]       <= req_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
